// File: rtl/sci_readout.sv
// sci_readout: snapshots eleven BCD count digits plus the decade counter's exponent,
// scans downward one digit per clock for the leading nonzero digit, and presents a
// truncated d.dd mantissa and decimal exponent as BCD and on four 7-segment displays.
module sci_readout #(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       capture,
  input  logic [3:0] ET0,
  input  logic [3:0] ET1,
  input  logic [3:0] ET2,
  input  logic [3:0] ET3,
  input  logic [3:0] ET4,
  input  logic [3:0] ET5,
  input  logic [3:0] ET6,
  input  logic [3:0] ET7,
  input  logic [3:0] ET8,
  input  logic [3:0] ET9,
  input  logic [3:0] ET10,
  input  logic [3:0] cur_exp,
  output logic [3:0] man2,
  output logic [3:0] man1,
  output logic [3:0] man0,
  output logic [3:0] exp_out,
  output logic       valid,
  output logic       busy,
  output logic [6:0] HEX3,
  output logic [6:0] HEX2,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t     state, state_next;
  logic [3:0] live [0:10];
  logic [3:0] snap [0:10];
  logic [3:0] idx;
  logic [3:0] start_idx;
  logic [3:0] dig_hi, dig_mid, dig_lo;
  logic       accept, hit;

  assign live[0]  = ET0;
  assign live[1]  = ET1;
  assign live[2]  = ET2;
  assign live[3]  = ET3;
  assign live[4]  = ET4;
  assign live[5]  = ET5;
  assign live[6]  = ET6;
  assign live[7]  = ET7;
  assign live[8]  = ET8;
  assign live[9]  = ET9;
  assign live[10] = ET10;

  // Glyph lookup, bit6..0 = g..a; 10 renders 'A', 11..15 render blank.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      4'd10:   s = 7'h77;
      default: s = 7'h00;
    endcase
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  // Scan start: one decade above the completed count, clamped to the top digit.
  always_comb begin
    start_idx = (cur_exp >= 4'd10) ? 4'd10 : cur_exp + 4'd1;
  end

  // Next-state logic and the three candidate mantissa digits at the scan position.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    hit        = 1'b0;
    dig_hi     = snap[idx];
    dig_mid    = (idx >= 4'd1) ? snap[idx - 4'd1] : 4'd0;
    dig_lo     = (idx >= 4'd2) ? snap[idx - 4'd2] : 4'd0;
    case (state)
      IDLE: begin
        if (capture) begin
          accept     = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (dig_hi != 4'd0 || idx == 4'd0) begin
          hit        = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Snapshot on acceptance, then walk the scan index down until a hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= 10; i++) snap[i] <= 4'd0;
      idx <= 4'd0;
    end else if (accept) begin
      for (int i = 0; i <= 10; i++) snap[i] <= live[i];
      idx <= start_idx;
    end else if (state == SCAN && !hit) begin
      idx <= idx - 4'd1;
    end
  end

  // Result registers: mantissa, exponent and displays update together on a hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      man2    <= 4'd0;
      man1    <= 4'd0;
      man0    <= 4'd0;
      exp_out <= 4'd0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      HEX3    <= seg7(4'd0);
      HEX2    <= seg7(4'd0);
      HEX1    <= seg7(4'd0);
      HEX0    <= seg7(4'd0);
    end else begin
      valid <= hit;
      if (accept) busy <= 1'b1;
      if (hit) begin
        busy    <= 1'b0;
        man2    <= dig_hi;
        man1    <= dig_mid;
        man0    <= dig_lo;
        exp_out <= idx;
        HEX3    <= seg7(dig_hi);
        HEX2    <= seg7(dig_mid);
        HEX1    <= seg7(dig_lo);
        HEX0    <= seg7(idx);
      end
    end
  end

endmodule
